// File: rtl/instr_encode_loader_pkg.sv
// Shared LEGv8 instruction definitions: format codes, field bit positions and
// loader state encoding. The decode-stage parser uses the same positions.
package instr_encode_loader_pkg;

    localparam int INSTR_LEN = 32;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_D  = 2'd1,
        FMT_B  = 2'd2,
        FMT_CB = 2'd3
    } fmt_e;

    // Field widths as carried on the tuple interface
    localparam int OPC_W   = 11;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 6;
    localparam int IMM_W   = 26;

    // Bit positions inside the 32-bit machine word
    localparam int OPC_HI    = 31;
    localparam int OPC_R_LO  = 21;
    localparam int OPC_B_LO  = 26;
    localparam int OPC_CB_LO = 24;
    localparam int RM_HI     = 20;
    localparam int RM_LO     = 16;
    localparam int SHAMT_HI  = 15;
    localparam int SHAMT_LO  = 10;
    localparam int DT_HI     = 20;
    localparam int DT_LO     = 12;
    localparam int OP2_HI    = 11;
    localparam int OP2_LO    = 10;
    localparam int RN_HI     = 9;
    localparam int RN_LO     = 5;
    localparam int RD_HI     = 4;
    localparam int RD_LO     = 0;
    localparam int BR_HI     = 25;
    localparam int BR_LO     = 0;
    localparam int CBR_HI    = 23;
    localparam int CBR_LO    = 5;

    localparam int DT_W  = DT_HI - DT_LO + 1;
    localparam int BR_W  = BR_HI - BR_LO + 1;
    localparam int CBR_W = CBR_HI - CBR_LO + 1;
    localparam int OPC_B_W  = OPC_HI - OPC_B_LO + 1;
    localparam int OPC_CB_W = OPC_HI - OPC_CB_LO + 1;

    typedef struct packed {
        fmt_e               fmt;
        logic [OPC_W-1:0]   opcode;
        logic [REG_W-1:0]   rm;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rd;
        logic [SHAMT_W-1:0] shamt;
        logic [IMM_W-1:0]   imm;
    } fields_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded instruction fields in, LEGv8 machine word out,
// plus a flag for immediates that do not fit their encoded width.
module instr_pack
    import instr_encode_loader_pkg::*;
(
    input  fields_t              fields,
    output logic [INSTR_LEN-1:0] word,
    output logic                 range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (fields.fmt)
            FMT_R: begin
                word[OPC_HI:OPC_R_LO]     = fields.opcode;
                word[RM_HI:RM_LO]         = fields.rm;
                word[SHAMT_HI:SHAMT_LO]   = fields.shamt;
                word[RN_HI:RN_LO]         = fields.rn;
                word[RD_HI:RD_LO]         = fields.rd;
            end
            FMT_D: begin
                word[OPC_HI:OPC_R_LO]     = fields.opcode;
                word[DT_HI:DT_LO]         = fields.imm[DT_W-1:0];
                word[OP2_HI:OP2_LO]       = 2'b00;
                word[RN_HI:RN_LO]         = fields.rn;
                word[RD_HI:RD_LO]         = fields.rd;
                range_err                 = |fields.imm[IMM_W-1:DT_W];
            end
            FMT_B: begin
                // opcode is left-justified; the unused low bits are dropped silently
                word[OPC_HI:OPC_B_LO]     = fields.opcode[OPC_W-1:OPC_W-OPC_B_W];
                word[BR_HI:BR_LO]         = fields.imm[BR_W-1:0];
            end
            FMT_CB: begin
                word[OPC_HI:OPC_CB_LO]    = fields.opcode[OPC_W-1:OPC_W-OPC_CB_W];
                word[CBR_HI:CBR_LO]       = fields.imm[CBR_W-1:0];
                word[RD_HI:RD_LO]         = fields.rd;
                range_err                 = |fields.imm[IMM_W-1:CBR_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams decoded field tuples into IMEM as packed LEGv8 words, sequentially
// from a programmable base address, through a one-entry output register.
//
//   state | meaning
//   IDLE  | waiting for start; no writes pending
//   LOAD  | accepting tuples, one word per cycle when memory is ready
//   DRAIN | last tuple accepted; waiting for its write to complete
module instr_encode_loader #(
    parameter int INSTR_LEN = instr_encode_loader_pkg::INSTR_LEN,
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [1:0]           in_fmt,
    input  logic [10:0]          in_opcode,
    input  logic [4:0]           in_rm,
    input  logic [4:0]           in_rn,
    input  logic [4:0]           in_rd,
    input  logic [5:0]           in_shamt,
    input  logic [25:0]          in_imm,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [INSTR_LEN-1:0] mem_wdata,
    input  logic                 mem_ready,
    output logic [CNT_W-1:0]     count,
    output logic                 range_err,
    output logic                 done
);

    import instr_encode_loader_pkg::*;

    state_e                state_q;
    state_e                state_d;
    fields_t               fields;
    logic [INSTR_LEN-1:0]  packed_word;
    logic                  pack_err;
    logic                  accept;
    logic                  wr_done;
    logic [ADDR_W-1:0]     base_aligned;

    assign fields = '{
        fmt:    fmt_e'(in_fmt),
        opcode: in_opcode,
        rm:     in_rm,
        rn:     in_rn,
        rd:     in_rd,
        shamt:  in_shamt,
        imm:    in_imm
    };

    instr_pack u_pack (
        .fields    (fields),
        .word      (packed_word),
        .range_err (pack_err)
    );

    assign in_ready     = (state_q == LOAD) && (!mem_we || mem_ready);
    assign accept       = in_valid && in_ready;
    assign wr_done      = mem_we && mem_ready;
    assign done         = (state_q == DRAIN) && wr_done;
    assign base_aligned = base_addr & ~ADDR_W'(3);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)              state_d = LOAD;
            LOAD:    if (accept && in_last)  state_d = DRAIN;
            DRAIN:   if (wr_done)            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            range_err <= 1'b0;
        end else begin
            state_q <= state_d;

            // mem_addr always names the word currently held in the output register
            if (wr_done) begin
                mem_addr <= mem_addr + ADDR_W'(4);
                count    <= count + CNT_W'(1);
            end

            if (accept) begin
                mem_we    <= 1'b1;
                mem_wdata <= packed_word;
                if (pack_err)
                    range_err <= 1'b1;
            end else if (wr_done) begin
                mem_we <= 1'b0;
            end

            if (state_q == IDLE && start) begin
                mem_addr  <= base_aligned;
                count     <= '0;
                range_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected writes are queued at
// tuple acceptance and popped as the memory side completes each write.
module tb_instr_encode_loader;
    import instr_encode_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  in_fmt;
    logic [10:0] in_opcode;
    logic [4:0]  in_rm;
    logic [4:0]  in_rn;
    logic [4:0]  in_rd;
    logic [5:0]  in_shamt;
    logic [25:0] in_imm;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] count;
    logic        range_err;
    logic        done;

    instr_encode_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rm     (in_rm),
        .in_rn     (in_rn),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count),
        .range_err (range_err),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          words_written = 0;
    int          stall_idx  = -1;
    int          stall_left = 0;
    logic        force_stall = 1'b0;
    logic [63:0] exp_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Memory side: stalls a chosen word for a few cycles, or stalls everything
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (force_stall)
                mem_ready = 1'b0;
            else if (mem_we && words_written == stall_idx && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else
                mem_ready = 1'b1;
        end
    end

    // Monitor: compares each completed write against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we && !mem_ready && sb.size() > 0) begin
                    check("hold_addr", mem_addr, sb[0].addr);
                    check("hold_data", 64'(mem_wdata), 64'(sb[0].data));
                    check("hold_in_ready", 64'(in_ready), 64'd0);
                end
                if (mem_we && mem_ready) begin
                    if (sb.size() == 0)
                        check("spurious_write", 64'd1, 64'd0);
                    else begin
                        e = sb.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", 64'(mem_wdata), 64'(e.data));
                        check("wr_done", 64'(done), 64'(e.last));
                    end
                    words_written++;
                end else if (done) begin
                    check("done_without_write", 64'(done), 64'd0);
                end
            end
        end
    end

    task automatic do_start(input logic [63:0] b, input logic takes_effect);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (takes_effect)
            exp_addr = b & ~64'h3;
    endtask

    task automatic send(input logic [1:0] fmt, input logic [10:0] opc,
                        input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd,
                        input logic [5:0] sh, input logic [25:0] imm, input logic last,
                        input logic [31:0] exp_word);
        logic acc;
        bit   ok;
        exp_t e;
        in_fmt = fmt; in_opcode = opc; in_rm = rm; in_rn = rn; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_last = last; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                e.addr = exp_addr;
                e.data = exp_word;
                e.last = last;
                sb.push_back(e);
                exp_addr = exp_addr + 64'd4;
                ok = 1;
                break;
            end
        end
        if (!ok)
            check("accept_timeout", 64'd0, 64'd1);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++)
            @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic prog_three();
        send(FMT_D, 11'b11111000010, 5'd0, 5'd10, 5'd9, 6'd0, 26'd240, 1'b0, 32'hF84F0149);
        send(FMT_R, 11'b10001011000, 5'd9, 5'd21, 5'd10, 6'd0, 26'd0, 1'b0, 32'h8B0902AA);
        send(FMT_D, 11'b11111000000, 5'd0, 5'd10, 5'd9, 6'd0, 26'd240, 1'b1, 32'hF80F0149);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rm = '0; in_rn = '0; in_rd = '0;
        in_shamt = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back program, memory always ready
        do_start(64'h100, 1'b1);
        prog_three();
        wait_drain();
        check("p1_count", 64'(count), 64'd3);
        check("p1_range_err", 64'(range_err), 64'd0);

        // Same program, second word stalled for three cycles
        stall_idx  = words_written + 1;
        stall_left = 3;
        do_start(64'h100, 1'b1);
        prog_three();
        wait_drain();
        check("p2_count", 64'(count), 64'd3);
        check("p2_stall_used", 64'(stall_left), 64'd0);

        // B and CB at full immediate width; opcode low bits are don't-care
        do_start(64'h43, 1'b1);
        send(FMT_B, {6'b000101, 5'b10101}, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF, 1'b0, 32'h17FFFFFF);
        send(FMT_CB, {8'b10110100, 3'b111}, 5'd0, 5'd0, 5'd3, 6'd0, 26'h007FFFF, 1'b1, 32'hB4FFFFE3);
        wait_drain();
        check("bcb_count", 64'(count), 64'd2);
        check("bcb_range_err", 64'(range_err), 64'd0);

        // D immediate out of range: truncated word, sticky flag
        do_start(64'h180, 1'b1);
        send(FMT_D, 11'b11111000000, 5'd0, 5'd10, 5'd9, 6'd0, 26'h200, 1'b1, 32'hF8000149);
        wait_drain();
        check("d_range_err", 64'(range_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("d_range_err_sticky", 64'(range_err), 64'd1);

        // New start clears the flag; a start during LOAD is ignored
        do_start(64'h200, 1'b1);
        check("start_clears_range_err", 64'(range_err), 64'd0);
        send(FMT_D, 11'b11111000010, 5'd0, 5'd10, 5'd9, 6'd0, 26'd240, 1'b0, 32'hF84F0149);
        do_start(64'h800, 1'b0);
        send(FMT_R, 11'b10001011000, 5'd9, 5'd21, 5'd10, 6'd0, 26'd0, 1'b0, 32'h8B0902AA);
        send(FMT_D, 11'b11111000000, 5'd0, 5'd10, 5'd9, 6'd0, 26'd240, 1'b1, 32'hF80F0149);
        wait_drain();
        check("ign_start_count", 64'(count), 64'd3);

        // Reset while a write is pending drops it
        force_stall = 1'b1;
        do_start(64'h300, 1'b1);
        send(FMT_R, 11'b10001011000, 5'd9, 5'd21, 5'd10, 6'd0, 26'd0, 1'b0, 32'h8B0902AA);
        check("pend_mem_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_mem_we", 64'(mem_we), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_mem_addr", mem_addr, 64'd0);
        check("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_stall = 1'b0;
        @(posedge clk);
        #1;
        do_start(64'h0, 1'b1);
        send(FMT_D, 11'b11111000010, 5'd0, 5'd10, 5'd9, 6'd0, 26'd240, 1'b1, 32'hF84F0149);
        wait_drain();
        check("post_rst_count", 64'(count), 64'd1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
